// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop rx synchroniser and 16x oversampling tick; UART_RX_MAJORITY_EN selects 3-sample majority voting.
// rx_done_tick/dout/frame_err are registered one clk after the stop-sample tick; there is no backpressure, so the consumer must capture on the strobe.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [DVSR_W-1:0] dvsr,
  output logic [DBIT-1:0]   dout,
  output logic              rx_done_tick,
  output logic              frame_err,
  output logic              busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_r, state_nxt;
  logic [3:0]        s_r, s_nxt;
  logic [NW-1:0]     n_r, n_nxt;
  logic [DBIT-1:0]   b_r, b_nxt;
  logic [DBIT-1:0]   dout_nxt;
  logic              ferr_nxt;
  logic              done_nxt;

  logic              rx_m, rx_s;
  logic [DVSR_W-1:0] tcnt;
  logic              tick;
  logic              bit_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // >= so that lowering dvsr below the running count ticks on the next cycle
  assign tick = (tcnt >= dvsr);

  always_ff @(posedge clk) begin
    if (!rst_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

`ifdef UART_RX_MAJORITY_EN
  // samples from the two ticks preceding the current one; voted with rx_s
  logic [1:0] smp;

  always_ff @(posedge clk) begin
    if (!rst_n)    smp <= 2'b11;
    else if (tick) smp <= {smp[0], rx_s};
  end

  assign bit_val = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      s_r          <= '0;
      n_r          <= '0;
      b_r          <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      s_r          <= s_nxt;
      n_r          <= n_nxt;
      b_r          <= b_nxt;
      dout         <= dout_nxt;
      frame_err    <= ferr_nxt;
      rx_done_tick <= done_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state_r;
    s_nxt     = s_r;
    n_nxt     = n_r;
    b_nxt     = b_r;
    dout_nxt  = dout;
    ferr_nxt  = frame_err;
    done_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_r == 4'd7) begin
            s_nxt = '0;
            n_nxt = '0;
            // a high mid-start sample is a line glitch, not a frame
            state_nxt = bit_val ? IDLE : DATA;
          end else begin
            s_nxt = s_r + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_r == 4'd15) begin
            s_nxt = '0;
            b_nxt = {bit_val, b_r[DBIT-1:1]};
            if (n_r == NW'(DBIT-1)) state_nxt = STOP;
            else                    n_nxt     = n_r + 1'b1;
          end else begin
            s_nxt = s_r + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_r == 4'(SB_TICK-1)) begin
            dout_nxt  = b_r;
            ferr_nxt  = ~bit_val;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            s_nxt = s_r + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected {frame_err, byte}, a monitor pops on each rx_done_tick.
module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [20:0] dvsr;
  logic [7:0]  dout;
  logic        rx_done_tick;
  logic        frame_err;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  sb[$];
  logic [20:0] mcnt;
  logic        last_done = 1'b0;

  uart_rx #(.DBIT(8), .SB_TICK(16), .DVSR_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .dvsr(dvsr),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // independent model of the oversampling tick phase, used only to align stimulus
  always @(posedge clk) begin
    if (!rst_n)            mcnt <= '0;
    else if (mcnt >= dvsr) mcnt <= '0;
    else                   mcnt <= mcnt + 21'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // returns just after the clk edge that consumes a tick
  task automatic wait_tick();
    @(negedge clk);
    while (mcnt < dvsr) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // t indexes tick windows: 0..15 start, 16..143 data, 144..159 stop
  task automatic send_frame(input logic [7:0] data, input logic [7:0] exp_byte, input bit ferr,
                            input int glitch_t, input int abort_t, input int gap);
    logic lvl;
    if (abort_t < 0) sb.push_back({ferr, exp_byte});
    for (int t = 0; t < 160; t++) begin
      if (t == abort_t) break;
      if (t < 16)       lvl = 1'b0;
      else if (t < 144) lvl = data[3'((t - 16) / 16)];
      else              lvl = (ferr && t < 154) ? 1'b0 : 1'b1;
      if (t == glitch_t) lvl = ~lvl;
      rx = lvl;
      if (t == 80) check("busy_mid_frame", {31'd0, busy}, 32'd1);
      wait_tick();
    end
    if (abort_t < 0) begin
      rx = 1'b1;
      repeat (gap) wait_tick();
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (last_done) check("done_width", {31'd0, rx_done_tick}, 32'd0);
    if (rst_n && rx_done_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {24'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e[7:0]});
        check("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
      end
    end
    last_done = rx_done_tick;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         gt;
    logic [7:0] gexp;
    rx    = 1'b1;
    rst_n = 1'b0;
    dvsr  = 21'd26;
    repeat (5) @(posedge clk);
    #1;
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();

    send_frame(8'h55, 8'h55, 1'b0, -1, -1, 20);
    check("busy_after_55", {31'd0, busy}, 32'd0);

    rx = 1'b0;
    repeat (3) wait_tick();
    rx = 1'b1;
    repeat (16) wait_tick();
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_dout", {24'd0, dout}, 32'h55);

    send_frame(8'hA3, 8'hA3, 1'b1, -1, -1, 20);
    send_frame(8'h0F, 8'h0F, 1'b0, -1, -1, 20);

    send_frame(8'h00, 8'h00, 1'b0, -1, -1, 0);
    send_frame(8'hFF, 8'hFF, 1'b0, -1, -1, 0);
    send_frame(8'h81, 8'h81, 1'b0, -1, -1, 20);

    send_frame(8'h3C, 8'h3C, 1'b0, -1, 88, 0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) wait_tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 8'h3C, 1'b0, -1, -1, 20);

`ifdef UART_RX_MAJORITY_EN
    gt   = 54;
    gexp = 8'h5A;
`else
    gt   = 55;
    gexp = 8'h5E;
`endif
    send_frame(8'h5A, gexp, 1'b0, gt, -1, 20);

    repeat (50) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
